// File: rtl/keyboard_pkg.sv
// Shared PS/2 set-2 scancode constants, held-key bit layout and decoder state type.
// Imported by the key decoder and anything else that interprets keyboard bytes.
package keyboard_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_PAUSE = 8'hE1;

   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_SPACE = 8'h29;

   // Only meaningful after an E0 prefix; without it these are keypad keys.
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_UP    = 8'h75;

   localparam int DEF_PREFIX_TIMEOUT = 2_000_000;
   localparam int DEF_PAUSE_SKIP     = 7;

   localparam int KB_ARROW_L  = 0;
   localparam int KB_A        = 1;
   localparam int KB_ARROW_R  = 2;
   localparam int KB_D        = 3;
   localparam int KB_ARROW_UP = 4;
   localparam int KB_SPACE    = 5;

   localparam logic [5:0] MASK_LEFT  = 6'b00_00_11;
   localparam logic [5:0] MASK_RIGHT = 6'b00_11_00;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_EXT       = 4'd1,
      ST_BREAK     = 4'd2,
      ST_EXT_BREAK = 4'd3,
      ST_SKIP      = 4'd4
   } kd_state_t;

   function automatic logic [5:0] key_mask(input logic ext, input logic [7:0] code);
      logic [5:0] m;
      m = '0;
      if (ext) begin
         case (code)
            SC_LEFT:  m[KB_ARROW_L]  = 1'b1;
            SC_RIGHT: m[KB_ARROW_R]  = 1'b1;
            SC_UP:    m[KB_ARROW_UP] = 1'b1;
            default:  m = '0;
         endcase
      end else begin
         case (code)
            SC_A:     m[KB_A]     = 1'b1;
            SC_D:     m[KB_D]     = 1'b1;
            SC_SPACE: m[KB_SPACE] = 1'b1;
            default:  m = '0;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/key_decoder.sv
// Turns the PS/2 set-2 scancode stream into held left/right/jump levels,
// with last-pressed-wins resolution of opposing directions.
module key_decoder
   import keyboard_pkg::*;
#(
   parameter int PREFIX_TIMEOUT = DEF_PREFIX_TIMEOUT,
   parameter int PAUSE_SKIP     = DEF_PAUSE_SKIP
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ps2_data,
   input  logic       ps2_valid,
   output logic       left,
   output logic       right,
   output logic       jump,
   output logic       seq_error
);

   localparam int TW = ($clog2(PREFIX_TIMEOUT) < 1) ? 1 : $clog2(PREFIX_TIMEOUT);
   localparam int SW = ($clog2(PAUSE_SKIP + 1) < 1) ? 1 : $clog2(PAUSE_SKIP + 1);
   // Expiry is the cycle whose increment would reach PREFIX_TIMEOUT-1.
   localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 2);

   kd_state_t   state_q, state_d;
   logic [5:0]  held_q, held_d;
   logic        last_dir_q, last_dir_d;
   logic [SW-1:0] skip_q, skip_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic        left_q, left_d;
   logic        right_q, right_d;
   logic        jump_q, jump_d;
   logic        seq_error_q, seq_error_d;

   logic [5:0]  make_mask;
   logic [5:0]  brk_mask;
   logic        lvl_l;
   logic        lvl_r;

   always_comb begin
      state_d     = state_q;
      skip_d      = skip_q;
      tmo_d       = tmo_q;
      seq_error_d = 1'b0;
      make_mask   = '0;
      brk_mask    = '0;

      if (ps2_valid) begin
         tmo_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (ps2_data == SC_EXT) begin
                  state_d = ST_EXT;
               end else if (ps2_data == SC_BREAK) begin
                  state_d = ST_BREAK;
               end else if (ps2_data == SC_PAUSE) begin
                  state_d = ST_SKIP;
                  skip_d  = SW'(PAUSE_SKIP);
               end else begin
                  make_mask = key_mask(1'b0, ps2_data);
               end
            end
            ST_EXT: begin
               if (ps2_data == SC_BREAK) begin
                  state_d = ST_EXT_BREAK;
               end else begin
                  make_mask = key_mask(1'b1, ps2_data);
                  state_d   = ST_IDLE;
               end
            end
            ST_BREAK: begin
               brk_mask = key_mask(1'b0, ps2_data);
               state_d  = ST_IDLE;
            end
            ST_EXT_BREAK: begin
               // Fake-shift codes (12, 7C) have no mask and fall through harmlessly.
               brk_mask = key_mask(1'b1, ps2_data);
               state_d  = ST_IDLE;
            end
            ST_SKIP: begin
               skip_d = skip_q - 1'b1;
               if (skip_q <= SW'(1)) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         if (tmo_q == TMO_LAST) begin
            state_d     = ST_IDLE;
            seq_error_d = 1'b1;
            tmo_d       = '0;
         end else if (tmo_q != '1) begin
            tmo_d = tmo_q + 1'b1;
         end
      end else begin
         tmo_d = '0;
      end

      held_d     = (held_q | make_mask) & ~brk_mask;
      last_dir_d = last_dir_q;
      if ((make_mask & MASK_LEFT) != '0) begin
         last_dir_d = 1'b0;
      end
      if ((make_mask & MASK_RIGHT) != '0) begin
         last_dir_d = 1'b1;
      end

      lvl_l   = held_d[KB_ARROW_L] | held_d[KB_A];
      lvl_r   = held_d[KB_ARROW_R] | held_d[KB_D];
      left_d  = lvl_l & (~lvl_r | ~last_dir_d);
      right_d = lvl_r & (~lvl_l | last_dir_d);
      jump_d  = held_d[KB_ARROW_UP] | held_d[KB_SPACE];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         held_q      <= '0;
         last_dir_q  <= 1'b0;
         skip_q      <= '0;
         tmo_q       <= '0;
         left_q      <= 1'b0;
         right_q     <= 1'b0;
         jump_q      <= 1'b0;
         seq_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         held_q      <= held_d;
         last_dir_q  <= last_dir_d;
         skip_q      <= skip_d;
         tmo_q       <= tmo_d;
         left_q      <= left_d;
         right_q     <= right_d;
         jump_q      <= jump_d;
         seq_error_q <= seq_error_d;
      end
   end

   assign left      = left_q;
   assign right     = right_q;
   assign jump      = jump_q;
   assign seq_error = seq_error_q;

endmodule

// File: tb/tb_key_decoder.sv
// Scoreboard bench for key_decoder: stimulus queues expected {left,right,jump,seq_error}
// and a monitor compares whenever a check point is reached.
module tb_key_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ps2_data = 8'h00;
   logic       ps2_valid = 1'b0;
   logic       left, right, jump, seq_error;

   int   checks = 0;
   int   errors = 0;
   logic chk_req = 1'b0;
   logic async_armed = 1'b0;

   logic [3:0] exp_q[$];
   string      name_q[$];

   key_decoder #(.PREFIX_TIMEOUT(16), .PAUSE_SKIP(7)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ps2_data  (ps2_data),
      .ps2_valid (ps2_valid),
      .left      (left),
      .right     (right),
      .jump      (jump),
      .seq_error (seq_error)
   );

   always #5 clk = ~clk;

   task automatic do_check();
      logic [3:0] act;
      logic [3:0] exp_v;
      string      nm;
      act = {left, right, jump, seq_error};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_check got lrjs=%b required none", act);
      end else begin
         exp_v = exp_q.pop_front();
         nm    = name_q.pop_front();
         if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got lrjs=%b required %b", nm, act, exp_v);
         end else begin
            $display("ok   %s lrjs=%b", nm, act);
         end
      end
   endtask

   // Monitor: synchronous checks one negedge after a flagged cycle, async reset checks 1ns after.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            if (async_armed) begin
               #1;
               do_check();
            end
         end else if (chk_req) begin
            @(negedge clk);
            do_check();
         end
      end
   end

   task automatic expect_out(input string nm, input logic [3:0] e);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic send(input logic [7:0] b, input bit chk);
      ps2_data  = b;
      ps2_valid = 1'b1;
      chk_req   = chk;
      @(posedge clk);
      #1;
      ps2_valid = 1'b0;
      chk_req   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_only(input string nm, input logic [3:0] e);
      expect_out(nm, e);
      chk_req = 1'b1;
      @(posedge clk);
      #1;
      chk_req = 1'b0;
   endtask

   // Sends n bytes taken from seq, most significant byte first; checks after the last.
   task automatic txn(input string nm, input int n, input logic [23:0] seq, input logic [3:0] e);
      expect_out(nm, e);
      for (int i = n - 1; i >= 0; i--) begin
         send(seq[i*8 +: 8], i == 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got no_finish required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Expected encoding is {left, right, jump, seq_error}.
      check_only("reset_state", 4'b0000);
      txn("make_a",          1, 24'h00001C, 4'b1000);
      txn("break_a",         2, 24'h00F01C, 4'b0000);
      txn("make_arrow_r",    2, 24'h00E074, 4'b0100);
      txn("break_arrow_r",   3, 24'hE0F074, 4'b0000);
      txn("keypad_74",       1, 24'h000074, 4'b0000);
      txn("hold_a",          1, 24'h00001C, 4'b1000);
      txn("add_arrow_l",     2, 24'h00E06B, 4'b1000);
      txn("release_a",       2, 24'h00F01C, 4'b1000);
      txn("release_arrow_l", 3, 24'hE0F06B, 4'b0000);
      txn("hold_a2",         1, 24'h00001C, 4'b1000);
      txn("press_d",         1, 24'h000023, 4'b0100);
      txn("release_d",       2, 24'h00F023, 4'b1000);
      txn("release_a2",      2, 24'h00F01C, 4'b0000);
      txn("hold_d",          1, 24'h000023, 4'b0100);
      txn("press_a",         1, 24'h00001C, 4'b1000);
      txn("break_unheld",    2, 24'h00F029, 4'b1000);
      txn("release_a3",      2, 24'h00F01C, 4'b0100);
      txn("release_d2",      2, 24'h00F023, 4'b0000);

      // Prefix timeout: the 15th idle cycle after E0 is the expiry cycle.
      send(8'hE0, 1'b0);
      idle(14);
      check_only("timeout_err", 4'b0001);
      check_only("err_one_pulse", 4'b0000);
      txn("space_after_tmo", 1, 24'h000029, 4'b0010);
      txn("release_space",   2, 24'h00F029, 4'b0000);

      // A byte landing on the expiry cycle is still decoded as extended.
      send(8'hE0, 1'b0);
      idle(14);
      expect_out("valid_at_expiry", 4'b1000);
      send(8'h6B, 1'b1);
      check_only("no_late_err", 4'b1000);
      txn("release_arrow_l2", 3, 24'hE0F06B, 4'b0000);

      expect_out("pause_skip", 4'b0000);
      send(8'hE1, 1'b0);
      send(8'h1C, 1'b0);
      send(8'h29, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h1C, 1'b0);
      send(8'hE0, 1'b0);
      send(8'h29, 1'b0);
      send(8'h75, 1'b1);
      txn("space_after_pause", 1, 24'h000029, 4'b0010);
      txn("fake_shift",        3, 24'hE0F012, 4'b0010);
      txn("hold_a4",           1, 24'h00001C, 4'b1010);

      send(8'hE0, 1'b0);
      #1;
      expect_out("async_reset", 4'b0000);
      async_armed = 1'b1;
      rst_n = 1'b0;
      #3;
      async_armed = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      txn("after_reset_space", 1, 24'h000029, 4'b0010);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         @(negedge clk);
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain got pending=%0d required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
